gate_bist_checker: RTL and testbench
====================================

# gate_bist_checker

Self-test engine for the lab's combinational gate primitives (AND, OR, XOR and their inverses). On `start` it drives every input combination to a gate-under-test, waits a programmable settle time, samples the gate output, compares it with the expected truth-table value, and reports pass/fail, the mismatch count and the first failing vector. It moves the exhaustive stimulus-and-check job out of simulation-only benches into synthesizable hardware that can sit beside any gate instance on the board.

## Interface
- `N_IN`, 2, number of gate inputs (1..8).
- `SETTLE`, 2, cycles each vector is held before sampling (>=1).

- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a test run; accepted only in IDLE.
- `func_sel`  in  3  expected function, latched at start: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved (expected = 0).
- `dut_a`  out  N_IN  stimulus vector to the gate under test.
- `dut_y`  in  1  gate-under-test output (combinational from `dut_a`).
- `busy`  out  1  high from accepted start until DONE exits.
- `done`  out  1  one-cycle pulse, end of run.
- `pass`  out  1  run result, valid from `done` and held until next accepted start.
- `err_cnt`  out  N_IN+1  number of mismatching vectors in the last run.
- `fail_vec`  out  N_IN  first mismatching vector.
- `fail_valid`  out  1  `fail_vec` holds a captured value.

## Operation
- Reset (async, any state): state=IDLE; `dut_a`, `busy`, `done`, `pass`, `err_cnt`, `fail_vec`, `fail_valid` all 0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: when `start`=1 at an edge, latch `func_sel`, set vec=0 (`dut_a`=0), clear `err_cnt`, `fail_vec`, `fail_valid` and `pass`, load the settle counter with SETTLE-1, set `busy`=1, go to SETTLE. Otherwise remain in IDLE; `dut_a` holds its last value.
- SETTLE: hold `dut_a`. If the counter is 0, go to SAMPLE; otherwise decrement it.
- SAMPLE: compute expected = f(vec) using reductions (&, |, ^, and their inversions). Compare it with `dut_y` at the edge.
  - On a mismatch, increment `err_cnt`. If `fail_valid`=0, capture `fail_vec`=vec and set `fail_valid`=1.
  - If vec is all ones, go to DONE. Else increment vec, drive it on `dut_a`, reload the counter with SETTLE-1, and go to SETTLE.
- DONE: `done`=1 for exactly this cycle. `pass`=1 if the final `err_cnt` (including the last sample) is 0. The next state is IDLE and `busy` drops on exit.
- `start` in SETTLE, SAMPLE or DONE is ignored and not queued.
- `err_cnt` maximum is 2^N_IN, which fits in N_IN+1 bits, so no saturation logic is needed.
- With N_IN=1 the reductions degenerate to the single bit; XOR and XNOR then act as buffer and inverter.
- A `func_sel` change mid-run has no effect.

## Timing
- Each vector is held on `dut_a` for SETTLE+1 cycles: SETTLE cycles in SETTLE plus 1 in SAMPLE. `dut_y` is sampled at the last edge of that window.
- From the start-accept edge to entry into DONE: 2^N_IN*(SETTLE+1) cycles. For N_IN=2, SETTLE=2 this is 12 cycles, with `done` in cycle 13.
- All outputs are registered. `busy` rises on the edge that accepts `start`.
- `done` and `pass` update on the same edge.
- The earliest restart is a `start` sampled in the IDLE cycle immediately after DONE.

## Test plan
- Reset: assert `rst_n`=0 mid-clock -> all outputs 0 immediately and the FSM is in IDLE.
- Good AND gate, `func_sel`=0, N_IN=2, SETTLE=2 -> `dut_a` steps 00, 01, 10, 11, each held 3 cycles; `done` in cycle 13; `pass`=1, `err_cnt`=0, `fail_valid`=0.
- AND gate checked against `func_sel`=2 (XOR) -> mismatches at 01, 10 and 11; `err_cnt`=3, `fail_vec`=01, `fail_valid`=1, `pass`=0.
- `dut_y` stuck at 1, `func_sel`=3 (NAND) -> mismatch only at 11; `err_cnt`=1, `fail_vec`=11, `pass`=0.
- `start` held high throughout -> no restart while `busy`=1; a new run starts in the IDLE cycle after `done`, clearing `err_cnt` and `pass` on the accept edge.
- `rst_n` pulsed low while `dut_a`=10 -> everything clears; a following start gives a complete fresh 12-cycle run with the correct result.

Source files
------------

// File: rtl/gate_bist_checker.sv
// Exhaustive self-test engine for combinational gates (AND/OR/XOR and inverses).
// Steps every input vector, holds it SETTLE+1 cycles, and checks dut_y at the last edge.
module gate_bist_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func_sel,
  output logic [N_IN-1:0] dut_a,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] fail_vec,
  output logic            fail_valid
);

  localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t        state;
  logic [2:0]    func_q;
  logic [CW-1:0] cnt;
  logic          expected;
  logic          mismatch;
  logic          last_vec;
  logic [N_IN:0] err_next;

  // dut_a doubles as the vector register, so expected is a pure function of it
  always_comb begin
    expected = 1'b0;
    case (func_q)
      3'd0:    expected =  (&dut_a);
      3'd1:    expected =  (|dut_a);
      3'd2:    expected =  (^dut_a);
      3'd3:    expected = ~(&dut_a);
      3'd4:    expected = ~(|dut_a);
      3'd5:    expected = ~(^dut_a);
      default: expected = 1'b0;
    endcase
  end

  assign mismatch = (expected != dut_y);
  assign last_vec = &dut_a;
  assign err_next = err_cnt + {{N_IN{1'b0}}, mismatch};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      func_q     <= 3'd0;
      cnt        <= '0;
      dut_a      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            func_q     <= func_sel;
            dut_a      <= '0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
            cnt        <= CNT_LOAD;
            busy       <= 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) state <= S_SAMPLE;
          else           cnt   <= cnt - CW'(1);
        end
        S_SAMPLE: begin
          if (mismatch) begin
            err_cnt <= err_next;
            if (!fail_valid) begin
              fail_vec   <= dut_a;
              fail_valid <= 1'b1;
            end
          end
          if (last_vec) begin
            // pass must see this final sample, hence err_next rather than err_cnt
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= S_DONE;
          end else begin
            dut_a <= dut_a + N_IN'(1);
            cnt   <= CNT_LOAD;
            state <= S_SETTLE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench for gate_bist_checker (N_IN=2, SETTLE=2) driving a modelled AND gate or a stuck-at-1 output.
module tb_gate_bist_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] func_sel;
  logic [1:0] dut_a;
  logic       dut_y;
  logic       busy, done, pass, fail_valid;
  logic [2:0] err_cnt;
  logic [1:0] fail_vec;
  logic       stuck;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign dut_y = stuck ? 1'b1 : (&dut_a);

  gate_bist_checker #(.N_IN(2), .SETTLE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func_sel(func_sel),
    .dut_a(dut_a), .dut_y(dut_y), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_vec(fail_vec), .fail_valid(fail_valid)
  );

  task automatic accept(input logic [2:0] f);
    @(negedge clk);
    func_sel = f;
    start    = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; func_sel = 3'd0; stuck = 1'b0;
    #3;
    total++; if (dut_a !== 2'b00) $display("FAIL rst_dut_a: got %b want 00", dut_a); else passed++;
    total++; if ({busy, done, pass, fail_valid} !== 4'b0000) $display("FAIL rst_flags: got %b want 0000", {busy, done, pass, fail_valid}); else passed++;
    total++; if ({err_cnt, fail_vec} !== 5'b0) $display("FAIL rst_cnt_vec: got %b want 00000", {err_cnt, fail_vec}); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL rst_idle_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_good_and;
    stuck = 1'b0;
    accept(3'd0);
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL good_busy_rise: got %b want 1", busy); else passed++;
    total++; if (dut_a !== 2'b00) $display("FAIL good_first_vec: got %b want 00", dut_a); else passed++;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i < 12) begin
        total++; if (dut_a !== 2'(i / 3)) $display("FAIL good_dut_a cyc %0d: got %b want %b", i, dut_a, 2'(i / 3)); else passed++;
        total++; if (done !== 1'b0) $display("FAIL good_early_done cyc %0d: got %b want 0", i, done); else passed++;
      end
    end
    total++; if (done !== 1'b1) $display("FAIL good_done: got %b want 1", done); else passed++;
    total++; if (pass !== 1'b1) $display("FAIL good_pass: got %b want 1", pass); else passed++;
    total++; if (err_cnt !== 3'd0) $display("FAIL good_err_cnt: got %0d want 0", err_cnt); else passed++;
    total++; if (fail_valid !== 1'b0) $display("FAIL good_fail_valid: got %b want 0", fail_valid); else passed++;
    @(posedge clk); #1;
    total++; if ({busy, done, pass} !== 3'b001) $display("FAIL good_exit busy/done/pass: got %b want 001", {busy, done, pass}); else passed++;
  endtask

  task automatic test_and_vs_xor;
    stuck = 1'b0;
    accept(3'd2);
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin
        total++; if (fail_valid !== 1'b0) $display("FAIL xor_no_fail_at_00: got %b want 0", fail_valid); else passed++;
      end
      if (i == 6) begin
        total++; if ({err_cnt, fail_valid} !== 4'b0011) $display("FAIL xor_first_mismatch err/fv: got %b want 0011", {err_cnt, fail_valid}); else passed++;
        func_sel = 3'd0;
      end
    end
    total++; if (done !== 1'b1) $display("FAIL xor_done: got %b want 1", done); else passed++;
    total++; if (err_cnt !== 3'd3) $display("FAIL xor_err_cnt: got %0d want 3", err_cnt); else passed++;
    total++; if (fail_vec !== 2'b01) $display("FAIL xor_fail_vec: got %b want 01", fail_vec); else passed++;
    total++; if ({fail_valid, pass} !== 2'b10) $display("FAIL xor_fv_pass: got %b want 10", {fail_valid, pass}); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_stuck_nand;
    stuck = 1'b1;
    accept(3'd3);
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 9) begin
        total++; if ({err_cnt, fail_valid} !== 4'b0000) $display("FAIL nand_clean_prefix err/fv: got %b want 0000", {err_cnt, fail_valid}); else passed++;
      end
    end
    total++; if (done !== 1'b1) $display("FAIL nand_done: got %b want 1", done); else passed++;
    total++; if (err_cnt !== 3'd1) $display("FAIL nand_err_cnt: got %0d want 1", err_cnt); else passed++;
    total++; if (fail_vec !== 2'b11) $display("FAIL nand_fail_vec: got %b want 11", fail_vec); else passed++;
    total++; if ({fail_valid, pass} !== 2'b10) $display("FAIL nand_fv_pass: got %b want 10", {fail_valid, pass}); else passed++;
    @(posedge clk); #1;
    stuck = 1'b0;
  endtask

  task automatic test_back_to_back;
    stuck = 1'b0;
    accept(3'd2);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      total++; if (busy !== 1'b1) $display("FAIL b2b_busy cyc %0d: got %b want 1", i, busy); else passed++;
      if (i == 6) begin
        total++; if (dut_a !== 2'b10) $display("FAIL b2b_no_restart: got %b want 10", dut_a); else passed++;
      end
    end
    total++; if ({done, err_cnt} !== 4'b1011) $display("FAIL b2b_run1 done/err: got %b want 1011", {done, err_cnt}); else passed++;
    func_sel = 3'd0;
    @(posedge clk); #1;
    total++; if ({busy, done} !== 2'b00) $display("FAIL b2b_idle busy/done: got %b want 00", {busy, done}); else passed++;
    @(posedge clk); #1;
    total++; if ({busy, err_cnt, fail_valid, dut_a} !== 7'b1_000_0_00) $display("FAIL b2b_restart busy/err/fv/a: got %b want 1000000", {busy, err_cnt, fail_valid, dut_a}); else passed++;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
    end
    total++; if ({done, pass, err_cnt} !== 5'b11_000) $display("FAIL b2b_run2 done/pass/err: got %b want 11000", {done, pass, err_cnt}); else passed++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if ({busy, pass} !== 2'b10) $display("FAIL b2b_accept_clears_pass busy/pass: got %b want 10", {busy, pass}); else passed++;
    start = 1'b0;
  endtask

  task automatic test_reset_mid;
    // continues the run accepted at the end of test_back_to_back
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
    end
    total++; if (dut_a !== 2'b10) $display("FAIL rmid_pre_vec: got %b want 10", dut_a); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, done, pass, fail_valid, dut_a} !== 6'b0) $display("FAIL rmid_clear flags/a: got %b want 000000", {busy, done, pass, fail_valid, dut_a}); else passed++;
    total++; if ({err_cnt, fail_vec} !== 5'b0) $display("FAIL rmid_clear cnt/vec: got %b want 00000", {err_cnt, fail_vec}); else passed++;
    @(negedge clk); rst_n = 1'b1;
    accept(3'd0);
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 11) begin
        total++; if ({done, dut_a} !== 3'b0_11) $display("FAIL rmid_cyc11 done/a: got %b want 011", {done, dut_a}); else passed++;
      end
    end
    total++; if ({done, pass, err_cnt, fail_valid} !== 6'b11_000_0) $display("FAIL rmid_fresh done/pass/err/fv: got %b want 110000", {done, pass, err_cnt, fail_valid}); else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_good_and;
    test_and_vs_xor;
    test_stuck_nand;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
